uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Shares one `uart_transmitter` among `NUM_REQ` byte-stream requesters at packet granularity. Round-robin arbitration selects a requester, which then holds the transmitter until it marks a byte as `last`. The block sequences each byte: it pulses `tx_start` with the data, then waits for `tx_done_tick`. It sits between the protocol/telemetry sources and the transmitter's `tx_start`/`data_in`/`tx_busy`/`tx_done_tick` pins.

## Interface
- `NUM_REQ`, default 4: number of requesters; minimum 1.
- `DATA_BITS`, default 8: byte width; must match the transmitter.
- `TIMEOUT_CYCLES`, default 5_000_000: idle limit within a granted packet (100 ms at 50 MHz); used only with `UART_TX_SCHED_TIMEOUT_EN`.
- `GW` (localparam): `NUM_REQ>1 ? $clog2(NUM_REQ) : 1`.

Ports:
- `clk_50MHz` in 1: system clock. One clock; all logic on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in NUM_REQ: requester i has a byte available.
- `req_data` in NUM_REQ*DATA_BITS: byte of requester i at `[i*DATA_BITS +: DATA_BITS]`.
- `req_last` in NUM_REQ: byte is the final byte of the packet.
- `req_ready` out NUM_REQ: one-hot, one-cycle pulse; the byte is consumed.
- `frame_done` out NUM_REQ: one-cycle pulse when the last byte's stop bit completes.
- `frame_abort` out NUM_REQ: one-cycle pulse when a packet is aborted on timeout.
- `tx_start` out 1: to the transmitter; one-cycle pulse.
- `tx_data` out DATA_BITS: to the transmitter's `data_in`; valid while `tx_start` is high.
- `tx_busy` in 1: from the transmitter.
- `tx_done_tick` in 1: from the transmitter.
- `grant_valid` out 1: a packet owns the transmitter.
- `grant_id` out GW: owning requester.

## Operation
- States are IDLE, ISSUE and WAIT.
- **IDLE**
  - `grant_valid`=0.
  - If any `req_valid` is high, select the first set bit searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - Register `grant_id` and set `grant_valid`=1, then go to ISSUE.
- **ISSUE**
  - Fires when `req_valid[grant_id]` is high and `tx_busy` is low. In that cycle:
    - `tx_start`=1.
    - `tx_data`=`req_data[grant_id]`.
    - `req_ready[grant_id]`=1.
    - `last_q` is loaded from `req_last[grant_id]`.
    - Next state is WAIT.
  - Otherwise it stays in ISSUE with `tx_start`=0.
- **WAIT**
  - On `tx_done_tick` with `last_q`=1:
    - Pulse `frame_done[grant_id]`.
    - Set `rr_ptr`=(`grant_id`+1) mod NUM_REQ.
    - Go to IDLE.
  - On `tx_done_tick` with `last_q`=0: go to ISSUE.
- Bytes of a granted packet are never interleaved with other requesters. Requests from non-owners are ignored until the owning packet ends.
- `tx_start`, `tx_data` and `req_ready` are combinational decodes of the state and inputs. `tx_data` reads 0 when `tx_start` is 0.
- `rr_ptr` wraps from NUM_REQ-1 to 0. When NUM_REQ=1, `grant_id` is always 0.
- **Reset**
  - Every output is 0: `grant_valid`, `grant_id`, `tx_start`, `tx_data`, `req_ready`, `frame_done`, `frame_abort`.
  - State is IDLE, `rr_ptr`=0, `last_q`=0, timeout counter=0.
  - Reset mid-packet drops the packet silently, with no `frame_done` or `frame_abort`.
  - The top level drives the transmitter reset from `~reset_n`, so both blocks reset together.

## Timing
- Request to first `tx_start`: 2 cycles (IDLE arbitration, then ISSUE), provided `tx_busy`=0.
- Byte-to-byte gap: the cycle of `tx_done_tick` (WAIT to ISSUE), then `tx_start` in the next cycle if `req_valid` is high. This adds 1 clk of idle line per byte.
- The transmitter raises `tx_busy` in the same cycle as `tx_start`. The scheduler never issues two `tx_start` pulses without an intervening `tx_done_tick`.
- `tx_done_tick` outside WAIT is ignored.
- `frame_done` coincides with the final `tx_done_tick`. A new arbitration happens in the following cycle (IDLE).

## Configuration
- **`UART_TX_SCHED_TIMEOUT_EN` defined**
  - A counter runs while in ISSUE with `req_valid[grant_id]`=0. It clears on entering ISSUE and on any issue.
  - On reaching TIMEOUT_CYCLES-1:
    - Pulse `frame_abort[grant_id]`.
    - Set `rr_ptr`=`grant_id`+1.
    - Go to IDLE.
- **Macro undefined**
  - The counter is not built and `frame_abort` is tied to 0.
  - A stalled owner holds the grant indefinitely. `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `uart_pkg` holds:
  - state localparams `S_IDLE`/`S_ISSUE`/`S_WAIT` (2-bit);
  - the default `DATA_BITS`=8;
  - the default timeout at 50 MHz.
- One sub-module, `rr_arbiter`:
  - inputs: request vector and `rr_ptr`;
  - outputs: winner index and `any`;
  - purely combinational, instantiated once.

## Test plan
- **Single byte.** Req 2 sends 0xA5 with `last`=1 from IDLE → `tx_start` 2 cycles later with `tx_data`=0xA5 and `req_ready`=0b0100. The serial line shows 0xA5 LSB-first. `frame_done[2]` pulses on the stop-bit tick.
- **Packet atomicity.** Req0 sends 3 bytes (0x01, 0x02, 0x03 last) while req1 holds valid → bytes go out 01, 02, 03 uninterrupted. Req1's byte is issued only after `frame_done[0]`.
- **Round-robin.** All 4 requesters continuously send 1-byte packets → grant order 0, 1, 2, 3, 0. Wrap occurs after index 3.
- **Stall and reset.** Req3 sends its first byte and then drops valid for 1000 cycles → no `tx_start`, grant held. Pulling `reset_n` low for 1 cycle → all outputs 0, state IDLE, `rr_ptr`=0.
- **Timeout (`UART_TX_SCHED_TIMEOUT_EN`, TIMEOUT_CYCLES=100).** Same stall as the previous case → `frame_abort[3]` pulses exactly 100 cycles after entering ISSUE. Grant passes to req0.
- **NUM_REQ=1.** Back-to-back packets → `grant_id` stays 0. Each new packet starts 1 cycle after the previous `frame_done`, with `tx_start` in the following cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and
// default byte width / idle timeout (100 ms at 50 MHz).
// No logic; imported by uart_tx_scheduler.
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   localparam int DEF_DATA_BITS      = 8;
   localparam int DEF_TIMEOUT_CYCLES = 5_000_000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request bit at or above ptr, wrapping modulo N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is taken.
// Ports: req (request vector), ptr (search start), idx (winner), any (some request set).
module rr_arbiter #(
   parameter int N  = 4,
   parameter int GW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] ptr,
   output logic [GW-1:0] idx,
   output logic          any
);

   // Walk the offsets from the far end back to ptr so the nearest set bit
   // (smallest offset) is the last one written and therefore wins.
   always_comb begin
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            idx = GW'((int'(ptr) + k) % N);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters, one whole packet per grant.
// Latency: request to tx_start 2 cycles; one idle cycle between bytes (the tx_done_tick cycle).
// Backpressure: req_ready pulses only when the owner's byte is handed to an idle transmitter.
// Ports: req_valid/req_data/req_last in, req_ready/frame_done/frame_abort out per requester;
//        tx_start/tx_data out and tx_busy/tx_done_tick in towards the transmitter;
//        grant_valid/grant_id report the current packet owner.
// Optional: define UART_TX_SCHED_TIMEOUT_EN to abort a packet whose owner goes quiet for
//           TIMEOUT_CYCLES cycles while a byte is due; otherwise the owner holds the grant.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter  int NUM_REQ        = 4,
   parameter  int DATA_BITS      = DEF_DATA_BITS,
   parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                         clk_50MHz,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
   input  logic [NUM_REQ-1:0]           req_last,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           frame_done,
   output logic [NUM_REQ-1:0]           frame_abort,
   output logic                         tx_start,
   output logic [DATA_BITS-1:0]         tx_data,
   input  logic                         tx_busy,
   input  logic                         tx_done_tick,
   output logic                         grant_valid,
   output logic [GW-1:0]                grant_id
);

   if (NUM_REQ < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("uart_tx_scheduler: NUM_REQ must be >= 1 and TIMEOUT_CYCLES >= 2");
   end

   state_t              state, state_d;
   logic [GW-1:0]       grant_d, rr_ptr, rr_ptr_d, next_ptr, arb_idx;
   logic                last_q, last_d, arb_any, issue;
   logic                own_valid, own_last;
   logic [DATA_BITS-1:0] own_data;
   logic [NUM_REQ-1:0]  own_onehot;

   rr_arbiter #(.N(NUM_REQ), .GW(GW)) u_arb (
      .req (req_valid),
      .ptr (rr_ptr),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Owner's lane, selected by compare rather than variable index so that
   // NUM_REQ=1 needs no special case.
   always_comb begin
      own_valid  = 1'b0;
      own_last   = 1'b0;
      own_data   = '0;
      own_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == GW'(i)) begin
            own_valid     = req_valid[i];
            own_last      = req_last[i];
            own_data      = req_data[i*DATA_BITS +: DATA_BITS];
            own_onehot[i] = 1'b1;
         end
      end
   end

   assign next_ptr    = (int'(grant_id) >= NUM_REQ - 1) ? '0 : grant_id + GW'(1);
   assign issue       = (state == S_ISSUE) && own_valid && !tx_busy;
   assign grant_valid = (state != S_IDLE);

`ifdef UART_TX_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] to_cnt, to_cnt_d;
   logic          to_abort;

   assign to_abort = (state == S_ISSUE) && !own_valid && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Held at zero outside ISSUE, so every entry into ISSUE starts a fresh count.
   // A present byte blocked only by tx_busy freezes the count.
   always_comb begin
      to_cnt_d = to_cnt;
      if (state != S_ISSUE || issue || to_abort) begin
         to_cnt_d = '0;
      end else if (!own_valid) begin
         to_cnt_d = to_cnt + TW'(1);
      end
   end

   always_ff @(posedge clk_50MHz) begin
      if (!reset_n) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt_d;
      end
   end

   assign frame_abort = to_abort ? own_onehot : '0;
`else
   assign frame_abort = '0;
`endif

   always_comb begin
      state_d    = state;
      grant_d    = grant_id;
      rr_ptr_d   = rr_ptr;
      last_d     = last_q;
      tx_start   = 1'b0;
      tx_data    = '0;
      req_ready  = '0;
      frame_done = '0;
      case (state)
         S_IDLE: begin
            if (arb_any) begin
               grant_d = arb_idx;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (issue) begin
               tx_start  = 1'b1;
               tx_data   = own_data;
               req_ready = own_onehot;
               last_d    = own_last;
               state_d   = S_WAIT;
            end
`ifdef UART_TX_SCHED_TIMEOUT_EN
            else if (to_abort) begin
               rr_ptr_d = next_ptr;
               state_d  = S_IDLE;
            end
`endif
         end
         S_WAIT: begin
            if (tx_done_tick) begin
               if (last_q) begin
                  frame_done = own_onehot;
                  rr_ptr_d   = next_ptr;
                  state_d    = S_IDLE;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_50MHz) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
         last_q   <= 1'b0;
      end else begin
         state    <= state_d;
         grant_id <= grant_d;
         rr_ptr   <= rr_ptr_d;
         last_q   <= last_d;
      end
   end

endmodule
